// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT result read-out path.
// Bit reversal is used only when FFT_RD_BITREV_EN is defined.
package fft_pkg;

  localparam int CPLX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rdr_state_t;

  typedef struct packed {
    logic [CPLX_W-1:0] re;
    logic [CPLX_W-1:0] im;
  } cplx_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [15:0] bitrev(
    input logic [15:0] v,
    input int unsigned w
  );
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(w)) r[i] = v[int'(w) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_rd_skid.sv
// Two-entry FIFO that buffers returned RAM words with their bin index.
// The head entry holds still until it is popped.
module fft_rd_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  assign dout  = mem_q[rp_q];
  assign count = cnt_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/fft_result_reader.sv
// Reads the final-stage RAM bank after finish and streams bins in order.
// Define FFT_RD_BITREV_EN to read the RAM in bit-reversed address order.
module fft_result_reader
  import fft_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int DATA_SIZE = 16,
  parameter int ADDR_W    = $clog2(N_SAMPLES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   finish,
  input  logic                   bank_sel,
  output logic                   rd_en,
  output logic                   rd_bank,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [2*DATA_SIZE-1:0] rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*DATA_SIZE-1:0] out_data,
  output logic [ADDR_W-1:0]      out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int DW = 2 * DATA_SIZE;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);

  rdr_state_t state_q, state_d;

  logic [ADDR_W-1:0]    rc_q;
  logic [ADDR_W-1:0]    ec_q;
  logic [ADDR_W-1:0]    fl_idx_q;
  logic                 fl_q;
  logic                 bank_q;
  logic                 done_q;
  logic                 pop;
  logic                 empty;
  logic                 skid_full_unused;
  logic [1:0]           count;
  logic [2:0]           occ;
  logic [DW+ADDR_W-1:0] head;

  assign pop = out_valid & out_ready;
  assign occ = {1'b0, count} + {2'b0, fl_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (finish) state_d = READ;
      READ:    if (rd_en && rc_q == LAST) state_d = DRAIN;
      DRAIN:   if (pop && ec_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pop this cycle frees a slot, so reads resume on the popping cycle.
  always_comb begin
    busy    = 1'b0;
    rd_en   = 1'b0;
    overrun = 1'b0;
    if (state_q != IDLE) busy = 1'b1;
    if (state_q == READ && occ < 3'd2 + {2'b0, pop}) rd_en = 1'b1;
    if (finish && busy) overrun = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q     <= '0;
      ec_q     <= '0;
      fl_q     <= 1'b0;
      fl_idx_q <= '0;
      bank_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fl_q     <= rd_en;
      fl_idx_q <= rc_q;
      done_q   <= pop && ec_q == LAST && state_q == DRAIN;
      if (state_q == IDLE && finish) begin
        bank_q <= bank_sel;
        rc_q   <= '0;
        ec_q   <= '0;
      end else begin
        if (rd_en) rc_q <= rc_q + 1'b1;
        if (pop)   ec_q <= ec_q + 1'b1;
      end
    end
  end

  fft_rd_skid #(
    .W(DW + ADDR_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (fl_q),
    .din   ({rd_data, fl_idx_q}),
    .pop   (pop),
    .dout  (head),
    .full  (skid_full_unused),
    .empty (empty),
    .count (count)
  );

`ifdef FFT_RD_BITREV_EN
  assign rd_addr = ADDR_W'(bitrev(16'(rc_q), ADDR_W));
`else
  assign rd_addr = rc_q;
`endif

  assign rd_bank   = bank_q;
  assign done      = done_q;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : head[DW+ADDR_W-1:ADDR_W];
  assign out_index = empty ? '0 : head[ADDR_W-1:0];
  assign out_last  = out_valid && out_index == LAST;

endmodule
